window_gen: RTL and testbench
=============================

Name: window_gen

Overview:
- Raster-to-window stage directly upstream of the convolution engine (conv / conv_new).
- Accepts one pixel_pkg::pixel_t per beat in row-major raster order.
- Buffers DIM-1 full lines and emits a DIMxDIM pixel_pkg::chunk_t window for every fully-interior pixel position.
- The conv stage consumes the output stream unchanged.

Parameters:
- IMG_W, 640, pixels per line (>= DIM)
- IMG_H, 480, lines per frame (>= DIM)
- DIM, 3, window edge length; must match pixel_pkg chunk dimension and the downstream conv DIM

Ports:
- clk  input  1  system clock; all logic on posedge
- rst  input  1  synchronous, active-low reset (0 = reset), sampled on posedge clk
- en  input  1  stage enable; when 0 no input is accepted and no state advances
- axis_i  axis_if.slave  pixel_t  input pixel stream (data, vld, rdy)
- axis_o  axis_if.master  chunk_t  output window stream (data, vld, rdy)

Behaviour:
- Reset (rst==0 at posedge):
  - axis_o.vld=0, axis_o.data='0, axis_i.rdy=0 during reset
  - col=0, row=0, state=FILL
  - Line-buffer RAM is not cleared; stale contents are never emitted because FILL gates output.
- Input ready: axis_i.rdy = rst & en & (!axis_o.vld | axis_o.rdy). This is combinational from axis_o.rdy; it is the only comb path.
- Accept: an input beat is accepted when axis_i.vld & axis_i.rdy.
- Window registers shift on each accept:
  - Column j=DIM-1 of the window loads {linebuf[DIM-2..0] at col, new pixel}.
  - Line buffers write the new pixel and cascade the old value at address col.
- Indexing: chunk[i][j]; i=0 is the oldest (top) row, i=DIM-1 is the current row; j=0 is the leftmost column.
- Emit rule: when the accepted pixel has row>=DIM-1 and col>=DIM-1, axis_o.data loads the window and axis_o.vld=1 on the next cycle. Latency is exactly 1 cycle from accept.
- Output register:
  - axis_o.vld clears on handshake (vld & rdy) unless a new window loads in the same cycle.
  - axis_o.data is held stable while vld & !rdy.
- FSM:
  - FILL: row<DIM-1; accepts pixels, never emits. Moves to STREAM on accept of (row=DIM-2, col=IMG_W-1).
  - STREAM: emits per the emit rule. On accept of (IMG_H-1, IMG_W-1), returns to FILL with row=col=0 (frame wrap).
- Counters: col wraps at IMG_W-1 with row+1; row wraps at IMG_H-1.
- Output count: exactly (IMG_W-DIM+1)*(IMG_H-DIM+1) windows per frame.
- Row start: windows spanning a row boundary (col<DIM-1) are suppressed, not emitted.
- Simultaneous output handshake and new window load in the same cycle: new data loads and vld stays 1 (full throughput, 1 window/cycle).
- en low mid-frame: counters, line buffers and axis_o are frozen; a pending axis_o.vld stays asserted and may still complete its handshake.
- Reset mid-frame: pending output is dropped; next accepted pixel is treated as (0,0).

Optional Feature:
- WINDOW_GEN_FRAME_CNT_EN defined:
  - Adds output port frame_cnt [15:0], reset 0.
  - Increments on accept of the last pixel of a frame; wraps 16'hFFFF->0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- pixel_pkg: pixel_t and chunk_t (existing); add a window_gen state enum (FILL, STREAM) and a localparam function for col/row counter widths ($clog2).
- Sub-module line_buf (parameters DEPTH=IMG_W, DATA_TYPE=pixel_t):
  - Single-clock, one read and one write at the same address per accept.
  - Returns the old value combinationally; write takes effect at posedge.
- window_gen instantiates DIM-1 line_buf instances.

Test Plan:
- Basic raster:
  - Setup: IMG_W=5, IMG_H=4, DIM=3; pixel k has red=k, grn=255-k, blu=0; vld=1, rdy=1 continuously.
  - First axis_o.vld one cycle after accepting k=12.
  - First window red rows {0,1,2},{5,6,7},{10,11,12}.
  - 6 windows per frame; last window red rows {7,8,9},{12,13,14},{17,18,19}.
- Backpressure:
  - Stimulus: axis_o.rdy=0 for 4 cycles after the first window.
  - axis_i.rdy=0 during the stall; data stays the {0..12} window; no window lost or duplicated across the frame.
- Back-to-back frames: 3 frames streamed continuously -> 18 windows total; the frame-2 first window equals the frame-1 first window. frame_cnt=3 at the end with WINDOW_GEN_FRAME_CNT_EN defined.
- Reset mid-frame:
  - Stimulus: rst=0 for 1 cycle after pixel 14.
  - axis_o.vld=0 next cycle; restarting at k=0 reproduces the basic-raster window sequence exactly.
- Enable gating: en=0 for 5 cycles at pixel 8 -> axis_i.rdy=0; no state change; the resumed output sequence is identical to the basic-raster case.
- Integration: window_gen feeding conv with the Laplacian kernel {-1,-1,-1;-1,8,-1;-1,-1,-1} on a constant 100-valued frame -> every conv output channel is 0.

Source files
------------

// File: rtl/pixel_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pixel_pkg : pixel/window types and window_gen shared definitions |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package pixel_pkg;

  localparam int CHUNK_DIM = 3;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] grn;
    logic [7:0] blu;
  } pixel_t;

  // chunk[i][j]: i=0 is the top (oldest) row, j=0 the leftmost column
  typedef pixel_t [CHUNK_DIM-1:0][CHUNK_DIM-1:0] chunk_t;

  typedef enum logic [0:0] {
    FILL   = 1'b0,
    STREAM = 1'b1
  } wg_state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | axis_if : valid/ready stream with a typed payload                |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
interface axis_if #(
  parameter type T = logic
);
  T     data;
  logic vld;
  logic rdy;

  modport master (output data, output vld, input  rdy);
  modport slave  (input  data, input  vld, output rdy);
endinterface
`default_nettype wire

// File: rtl/line_buf.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | line_buf : one-line delay RAM, read-old / write-new per address  |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module line_buf
  import pixel_pkg::*;
#(
  parameter int  DEPTH     = 640,
  parameter type DATA_TYPE = pixel_t
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [cnt_width(DEPTH)-1:0] addr,
  input  DATA_TYPE                    wr_data,
  output DATA_TYPE                    rd_data
);

  DATA_TYPE mem [DEPTH];

  // Old contents are visible in the same cycle the new value is written
  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/window_gen.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | window_gen : raster pixel stream -> DIMxDIM interior windows     |
// | Option WINDOW_GEN_FRAME_CNT_EN adds the frame_cnt output.        |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module window_gen
  import pixel_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DIM   = CHUNK_DIM
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  axis_if.slave  axis_i,
  axis_if.master axis_o
`ifdef WINDOW_GEN_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int COL_W = cnt_width(IMG_W);
  localparam int ROW_W = cnt_width(IMG_H);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(DIM - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(DIM - 1);
  localparam logic [ROW_W-1:0] ROW_FILL  = ROW_W'(DIM - 2);

  wg_state_e        state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  chunk_t           win_q, win_d;
  chunk_t           data_q, data_d;
  logic             vld_q, vld_d;

  logic accept;
  logic last_col;
  logic last_row;
  logic emit;

  pixel_t lb_rd [DIM-1];

  assign axis_i.rdy  = rst & en & (~vld_q | axis_o.rdy);
  assign axis_o.vld  = vld_q;
  assign axis_o.data = data_q;

  assign accept   = axis_i.vld & axis_i.rdy;
  assign last_col = (col_q == COL_LAST);
  assign last_row = (row_q == ROW_LAST);
  assign emit     = accept & (state_q == STREAM) &
                    (row_q >= ROW_FIRST) & (col_q >= COL_FIRST);

  // Buffer 0 holds the previous line; each later buffer is one line older
  for (genvar k = 0; k < DIM - 1; k++) begin : g_line_buf
    pixel_t wr_px;
    if (k == 0) begin : g_head
      assign wr_px = axis_i.data;
    end else begin : g_tail
      assign wr_px = lb_rd[k-1];
    end
    line_buf #(
      .DEPTH     (IMG_W),
      .DATA_TYPE (pixel_t)
    ) u_line_buf (
      .clk     (clk),
      .we      (accept),
      .addr    (col_q),
      .wr_data (wr_px),
      .rd_data (lb_rd[k])
    );
  end

  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int i = 0; i < DIM; i++) begin
        for (int j = 0; j < DIM - 1; j++) begin
          win_d[i][j] = win_q[i][j+1];
        end
      end
      for (int i = 0; i < DIM - 1; i++) begin
        win_d[i][DIM-1] = lb_rd[DIM-2-i];
      end
      win_d[DIM-1][DIM-1] = axis_i.data;
    end
  end

  always_comb begin
    data_d = emit ? win_d : data_q;
    vld_d  = emit | (vld_q & ~axis_o.rdy);
  end

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
      case (state_q)
        FILL:    if (last_col && (row_q == ROW_FILL)) state_d = STREAM;
        STREAM:  if (last_col && last_row)            state_d = FILL;
        default: state_d = FILL;
      endcase
    end
  end

`ifdef WINDOW_GEN_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt = frame_cnt_q;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (accept && last_col && last_row) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FILL;
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
`ifdef WINDOW_GEN_FRAME_CNT_EN
      frame_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
`ifdef WINDOW_GEN_FRAME_CNT_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_window_gen.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_window_gen : directed self-checking bench, 5x4 image, DIM=3   |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module tb_window_gen;
  import pixel_pkg::*;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int D  = 3;
  localparam int NW = (W - D + 1) * (H - D + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;

  axis_if #(.T(pixel_t)) axis_i ();
  axis_if #(.T(chunk_t)) axis_o ();

`ifdef WINDOW_GEN_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int errors = 0;
  int checks = 0;
  chunk_t cap_q[$];

  window_gen #(
    .IMG_W (W),
    .IMG_H (H),
    .DIM   (D)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .axis_i (axis_i),
    .axis_o (axis_o)
`ifdef WINDOW_GEN_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Record every window that will complete a handshake on the next edge
  always @(negedge clk) begin
    #2;
    if (axis_o.vld && axis_o.rdy) cap_q.push_back(axis_o.data);
  end

  function automatic pixel_t mk(input int k);
    pixel_t p;
    p.red = 8'(k);
    p.grn = 8'(255 - k);
    p.blu = 8'd0;
    return p;
  endfunction

  // n-th window of a frame in emission order
  function automatic chunk_t exp_win(input int n);
    chunk_t w;
    int r, c;
    r = (D - 1) + n / (W - D + 1);
    c = (D - 1) + n % (W - D + 1);
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++)
        w[i][j] = mk((r - (D - 1) + i) * W + (c - (D - 1) + j));
    return w;
  endfunction

  function automatic bit is_emit(input int k);
    return ((k / W) >= D - 1) && ((k % W) >= D - 1);
  endfunction

  task automatic push(input pixel_t p);
    bit acc;
    axis_i.data = p;
    axis_i.vld  = 1'b1;
    for (int t = 0; t < 100; t++) begin
      #2;
      acc = axis_i.rdy;
      @(negedge clk);
      if (acc) return;
    end
    checks++;
    errors++;
    $display("FAIL push_timeout: accepted=0 required=1");
  endtask

  task automatic do_reset();
    rst = 1'b0;
    axis_i.vld = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cap_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en  = 1'b1;
    axis_o.rdy = 1'b1;
    axis_i.data = mk(3);
    axis_i.vld  = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if (axis_o.vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", axis_o.vld); end
    checks++;
    if (axis_o.data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", axis_o.data); end
    checks++;
    if (axis_i.rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", axis_i.rdy); end
    @(negedge clk);
    axis_i.vld = 1'b0;
    rst = 1'b1;
    cap_q.delete();
  endtask

  task automatic test_basic_raster();
    do_reset();
    for (int k = 0; k < W * H; k++) begin
      push(mk(k));
      checks++;
      if (axis_o.vld !== is_emit(k)) begin
        errors++;
        $display("FAIL basic_vld_after_k%0d: got %b want %b", k, axis_o.vld, is_emit(k));
      end
      if (k == 12) begin
        checks++;
        if (axis_o.data !== exp_win(0)) begin
          errors++;
          $display("FAIL basic_first_data: got %h want %h", axis_o.data, exp_win(0));
        end
      end
    end
    axis_i.vld = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cap_q.size() != NW) begin errors++; $display("FAIL basic_count: got %0d want %0d", cap_q.size(), NW); end
    for (int n = 0; n < NW && n < cap_q.size(); n++) begin
      checks++;
      if (cap_q[n] !== exp_win(n)) begin
        errors++;
        $display("FAIL basic_win[%0d]: got %h want %h", n, cap_q[n], exp_win(n));
      end
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    do_reset();
    fork
      begin
        for (int k = 0; k < W * H; k++) push(mk(k));
        axis_i.vld = 1'b0;
      end
      begin
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
          @(negedge clk);
          if (axis_o.vld) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
          errors++;
          $display("FAIL bp_first_vld: got 0 want 1");
        end else begin
          axis_o.rdy = 1'b0;
          for (int t = 0; t < 4; t++) begin
            #2;
            checks++;
            if (axis_i.rdy !== 1'b0) begin errors++; $display("FAIL bp_in_rdy[%0d]: got %b want 0", t, axis_i.rdy); end
            checks++;
            if (axis_o.vld !== 1'b1) begin errors++; $display("FAIL bp_vld[%0d]: got %b want 1", t, axis_o.vld); end
            checks++;
            if (axis_o.data !== exp_win(0)) begin
              errors++;
              $display("FAIL bp_hold[%0d]: got %h want %h", t, axis_o.data, exp_win(0));
            end
            @(negedge clk);
          end
          axis_o.rdy = 1'b1;
        end
      end
    join
    repeat (3) @(negedge clk);
    checks++;
    if (cap_q.size() != NW) begin errors++; $display("FAIL bp_count: got %0d want %0d", cap_q.size(), NW); end
    for (int n = 0; n < NW && n < cap_q.size(); n++) begin
      checks++;
      if (cap_q[n] !== exp_win(n)) begin
        errors++;
        $display("FAIL bp_win[%0d]: got %h want %h", n, cap_q[n], exp_win(n));
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < W * H; k++) push(mk(k));
    axis_i.vld = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cap_q.size() != 3 * NW) begin errors++; $display("FAIL b2b_count: got %0d want %0d", cap_q.size(), 3 * NW); end
    for (int n = 0; n < 3 * NW && n < cap_q.size(); n++) begin
      checks++;
      if (cap_q[n] !== exp_win(n % NW)) begin
        errors++;
        $display("FAIL b2b_win[%0d]: got %h want %h", n, cap_q[n], exp_win(n % NW));
      end
    end
`ifdef WINDOW_GEN_FRAME_CNT_EN
    checks++;
    if (frame_cnt !== 16'd3) begin errors++; $display("FAIL b2b_frame_cnt: got %0d want 3", frame_cnt); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    for (int k = 0; k <= 14; k++) push(mk(k));
    rst = 1'b0;
    axis_i.vld = 1'b0;
    @(negedge clk);
    checks++;
    if (axis_o.vld !== 1'b0) begin errors++; $display("FAIL rstmid_vld: got %b want 0", axis_o.vld); end
    checks++;
    if (axis_i.rdy !== 1'b0) begin errors++; $display("FAIL rstmid_rdy: got %b want 0", axis_i.rdy); end
    rst = 1'b1;
    cap_q.delete();
    for (int k = 0; k < W * H; k++) push(mk(k));
    axis_i.vld = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cap_q.size() != NW) begin errors++; $display("FAIL rstmid_count: got %0d want %0d", cap_q.size(), NW); end
    for (int n = 0; n < NW && n < cap_q.size(); n++) begin
      checks++;
      if (cap_q[n] !== exp_win(n)) begin
        errors++;
        $display("FAIL rstmid_win[%0d]: got %h want %h", n, cap_q[n], exp_win(n));
      end
    end
  endtask

  task automatic test_enable_gating();
    do_reset();
    for (int k = 0; k <= 8; k++) push(mk(k));
    en = 1'b0;
    axis_i.data = mk(9);
    axis_i.vld  = 1'b1;
    for (int t = 0; t < 5; t++) begin
      #2;
      checks++;
      if (axis_i.rdy !== 1'b0) begin errors++; $display("FAIL en_in_rdy[%0d]: got %b want 0", t, axis_i.rdy); end
      checks++;
      if (axis_o.vld !== 1'b0) begin errors++; $display("FAIL en_vld[%0d]: got %b want 0", t, axis_o.vld); end
      @(negedge clk);
    end
    en = 1'b1;
    for (int k = 9; k < W * H; k++) push(mk(k));
    axis_i.vld = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cap_q.size() != NW) begin errors++; $display("FAIL en_count: got %0d want %0d", cap_q.size(), NW); end
    for (int n = 0; n < NW && n < cap_q.size(); n++) begin
      checks++;
      if (cap_q[n] !== exp_win(n)) begin
        errors++;
        $display("FAIL en_win[%0d]: got %h want %h", n, cap_q[n], exp_win(n));
      end
    end
  endtask

  task automatic test_integration();
    pixel_t c100;
    chunk_t w;
    int acc [3];
    c100.red = 8'd100;
    c100.grn = 8'd100;
    c100.blu = 8'd100;
    do_reset();
    for (int k = 0; k < W * H; k++) push(c100);
    axis_i.vld = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cap_q.size() != NW) begin errors++; $display("FAIL lap_count: got %0d want %0d", cap_q.size(), NW); end
    for (int n = 0; n < NW && n < cap_q.size(); n++) begin
      w = cap_q[n];
      acc[0] = 0; acc[1] = 0; acc[2] = 0;
      for (int i = 0; i < D; i++)
        for (int j = 0; j < D; j++) begin
          int kc;
          kc = (i == 1 && j == 1) ? 8 : -1;
          acc[0] += kc * int'(w[i][j].red);
          acc[1] += kc * int'(w[i][j].grn);
          acc[2] += kc * int'(w[i][j].blu);
        end
      for (int ch = 0; ch < 3; ch++) begin
        checks++;
        if (acc[ch] != 0) begin
          errors++;
          $display("FAIL lap_win[%0d]_ch%0d: got %0d want 0", n, ch, acc[ch]);
        end
      end
    end
  endtask

  initial begin
    axis_i.vld  = 1'b0;
    axis_i.data = '0;
    axis_o.rdy  = 1'b1;
    en  = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_raster();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    test_enable_gating();
    test_integration();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
